// File: rtl/alu_pkg.sv
// Shared constants for the Hack-style ALU: function encodings and default width.
package alu_pkg;

   localparam int ALU_WIDTH = 16;

   typedef enum logic [1:0] {
      F_AND = 2'b00,
      F_ADD = 2'b01,
      F_OR  = 2'b10,
      F_XOR = 2'b11
   } alu_fn_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operand zero/invert, function mux, result
// invert and flag generation.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             zx_i,
   input  logic             nx_i,
   input  logic             zy_i,
   input  logic             ny_i,
   input  logic [1:0]       f_i,
   input  logic             no_i,
   output logic [WIDTH-1:0] res_o,
   output logic             zr_o,
   output logic             ng_o,
   output logic             cy_o
);

   logic [WIDTH-1:0] x1, x2, y1, y2, r;
   logic [WIDTH:0]   sum;

   always_comb begin
      x1  = zx_i ? '0 : a_i;
      x2  = nx_i ? ~x1 : x1;
      y1  = zy_i ? '0 : b_i;
      y2  = ny_i ? ~y1 : y1;
      sum = {1'b0, x2} + {1'b0, y2};
      r   = '0;
      case (alu_fn_e'(f_i))
         F_AND: r = x2 & y2;
         F_ADD: r = sum[WIDTH-1:0];
         F_OR:  r = x2 | y2;
         F_XOR: r = x2 ^ y2;
         default: r = '0;
      endcase
      res_o = no_i ? ~r : r;
      zr_o  = (res_o == '0);
      ng_o  = res_o[WIDTH-1];
      // carry reflects the raw adder, independent of the output invert
      cy_o  = (alu_fn_e'(f_i) == F_ADD) ? sum[WIDTH] : 1'b0;
   end

endmodule

// File: rtl/alu.sv
// Registered Hack-style ALU: one op per cycle, result and flags one clock later.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic [1:0]       f,
   input  logic             no,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             cy
);

   logic [WIDTH-1:0] res_d, out_q;
   logic             zr_d, ng_d, cy_d;
   logic             zr_q, ng_q, cy_q, vld_q;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a_i  (a),
      .b_i  (b),
      .zx_i (zx),
      .nx_i (nx),
      .zy_i (zy),
      .ny_i (ny),
      .f_i  (f),
      .no_i (no),
      .res_o(res_d),
      .zr_o (zr_d),
      .ng_o (ng_d),
      .cy_o (cy_d)
   );

   // result/flags only load on a valid op so they hold across idle cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         zr_q  <= 1'b1;
         ng_q  <= 1'b0;
         cy_q  <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= in_valid;
         if (in_valid) begin
            out_q <= res_d;
            zr_q  <= zr_d;
            ng_q  <= ng_d;
            cy_q  <= cy_d;
         end
      end
   end

   assign out_valid = vld_q;
   assign out       = out_q;
   assign zr        = zr_q;
   assign ng        = ng_q;
   assign cy        = cy_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed ops push expected results, a negedge
// monitor pops and compares whenever out_valid is high.
module tb_alu;

   typedef struct packed {
      logic [15:0] out;
      logic        zr;
      logic        ng;
      logic        cy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] a, b;
   logic        zx, nx, zy, ny, no;
   logic [1:0]  f;
   logic        out_valid;
   logic [15:0] out;
   logic        zr, ng, cy;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];

   alu #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .zx       (zx),
      .nx       (nx),
      .zy       (zy),
      .ny       (ny),
      .f        (f),
      .no       (no),
      .out_valid(out_valid),
      .out      (out),
      .zr       (zr),
      .ng       (ng),
      .cy       (cy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   // drive one valid op; expected zr/ng come from the hand-computed result
   task automatic op(input logic [15:0] ia, input logic [15:0] ib,
                     input logic izx, input logic inx, input logic izy, input logic iny,
                     input logic [1:0] ifn, input logic ino,
                     input logic [15:0] eout, input logic ecy);
      exp_t e;
      a = ia; b = ib; zx = izx; nx = inx; zy = izy; ny = iny; f = ifn; no = ino;
      in_valid = 1'b1;
      e.out = eout; e.zr = (eout == 16'h0); e.ng = eout[15]; e.cy = ecy;
      sb_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF; f = 2'b01;
      @(posedge clk); #1;
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out_valid", 16'(out_valid), 16'd0);
            end else begin
               e = sb_q.pop_front();
               chk("out", out, e.out);
               chk("zr", 16'(zr), 16'(e.zr));
               chk("ng", 16'(ng), 16'(e.ng));
               chk("cy", 16'(cy), 16'(e.cy));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b1;
      a = 16'h1; b = 16'h1; zx = 0; nx = 0; zy = 0; ny = 0; f = 2'b01; no = 0;
      #3;
      chk("rst_out", out, 16'h0);
      chk("rst_zr", 16'(zr), 16'd1);
      chk("rst_ng", 16'(ng), 16'd0);
      chk("rst_cy", 16'(cy), 16'd0);
      chk("rst_vld", 16'(out_valid), 16'd0);
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b0;
      @(posedge clk); #1;

      // AND / zeroing
      op(16'h0001, 16'h0001, 0,0,0,0, 2'b00, 0, 16'h0001, 0);
      op(16'h0001, 16'h0001, 1,0,0,0, 2'b00, 0, 16'h0000, 0);
      op(16'h0001, 16'h0001, 0,0,1,0, 2'b00, 0, 16'h0000, 0);
      // ADD, including wrap with carry
      op(16'h0001, 16'h0001, 0,0,0,0, 2'b01, 0, 16'h0002, 0);
      op(16'hFFFF, 16'h0001, 0,0,0,0, 2'b01, 0, 16'h0000, 1);
      // XOR with negated x
      op(16'h0001, 16'h0001, 0,1,0,0, 2'b11, 0, 16'hFFFF, 0);
      // Hack constants
      op(16'h1234, 16'h00FF, 1,1,1,1, 2'b01, 1, 16'h0001, 1);
      op(16'h1234, 16'h00FF, 1,1,1,0, 2'b01, 0, 16'hFFFF, 0);
      op(16'h1234, 16'h00FF, 0,0,0,0, 2'b10, 0, 16'h12FF, 0);
      op(16'h1234, 16'h00FF, 0,1,0,0, 2'b01, 1, 16'h1135, 0);
      idle();
      chk("q_drained", 16'(sb_q.size()), 16'd0);

      // handshake: three ops, then two idle edges with held result
      op(16'h00F0, 16'h0F0F, 0,0,0,0, 2'b00, 0, 16'h0000, 0);
      op(16'h00F0, 16'h0F0F, 0,0,0,0, 2'b10, 0, 16'h0FFF, 0);
      op(16'h8000, 16'h8000, 0,0,0,0, 2'b01, 1, 16'hFFFF, 1);
      idle();
      chk("hold1_vld", 16'(out_valid), 16'd0);
      chk("hold1_out", out, 16'hFFFF);
      chk("hold1_cy", 16'(cy), 16'd1);
      idle();
      chk("hold2_vld", 16'(out_valid), 16'd0);
      chk("hold2_out", out, 16'hFFFF);
      chk("hold2_ng", 16'(ng), 16'd1);

      // reset mid-stream: clear at once, in-flight op discarded
      op(16'h4000, 16'h4000, 0,0,0,0, 2'b01, 0, 16'h8000, 0);
      a = 16'h0003; b = 16'h0004; f = 2'b01; in_valid = 1'b1;
      #5;
      rst = 1'b1;
      #1;
      chk("mrst_out", out, 16'h0);
      chk("mrst_zr", 16'(zr), 16'd1);
      chk("mrst_ng", 16'(ng), 16'd0);
      chk("mrst_vld", 16'(out_valid), 16'd0);
      @(posedge clk); #1;
      chk("mrst_discard_vld", 16'(out_valid), 16'd0);
      chk("mrst_discard_out", out, 16'h0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      op(16'h0003, 16'h0004, 0,0,0,0, 2'b11, 0, 16'h0007, 0);
      idle();
      idle();
      chk("q_final_empty", 16'(sb_q.size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
